// File: rtl/sync_edge.sv
// sync_edge: brings an asynchronous level into the CLK domain and produces
// registered single-cycle rise/fall pulses. Reusable for buttons and other
// slow external inputs.
//
// Ports:
//   CLK    in   clock, all state on rising edge
//   RST_N  in   asynchronous active-low reset
//   D      in   asynchronous input level
//   LEVEL  out  synchronized level
//   RISE   out  one-cycle pulse, SYNC_STAGES+1 clocks after D is first sampled high
//   FALL   out  one-cycle pulse, SYNC_STAGES+1 clocks after D is first sampled low
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic D,
  output logic LEVEL,
  output logic RISE,
  output logic FALL
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;
  logic                   rise_q;
  logic                   fall_q;
  logic                   lvl;

  assign lvl = sync_q[SYNC_STAGES-1];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], D};
      dly_q  <= lvl;
      // Edge pulses are registered so downstream logic sees clean flop outputs.
      rise_q <= lvl & ~dly_q;
      fall_q <= ~lvl & dly_q;
    end
  end

  assign LEVEL = lvl;
  assign RISE  = rise_q;
  assign FALL  = fall_q;

endmodule

// File: rtl/blink_meter.sv
// blink_meter: measures period and high time of an asynchronous square wave
// in CLK cycles and reports each completed rise-to-rise cycle with a
// one-clock VALID strobe.
//
// Ports:
//   CLK        in   clock
//   RST_N      in   asynchronous active-low reset
//   SIG        in   asynchronous input being measured
//   PERIOD     out  last rise-to-rise interval (cycles)
//   HIGH_TIME  out  high cycles within that period
//   VALID      out  one-cycle strobe, PERIOD/HIGH_TIME updated with it
//   LOCKED     out  two consecutive periods were equal
//   TIMEOUT    out  sticky: counter saturated without a rising edge
module blink_meter #(
  parameter int CNT_WIDTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 SIG,
  output logic [CNT_WIDTH-1:0] PERIOD,
  output logic [CNT_WIDTH-1:0] HIGH_TIME,
  output logic                 VALID,
  output logic                 LOCKED,
  output logic                 TIMEOUT
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic rise, fall, level_unused;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .CLK   (CLK),
    .RST_N (RST_N),
    .D     (SIG),
    .LEVEL (level_unused),
    .RISE  (rise),
    .FALL  (fall)
  );

  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] hi_cap_q, hi_cap_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic [CNT_WIDTH-1:0] high_q, high_d;
  logic                 valid_q, valid_d;
  logic                 locked_q, locked_d;
  logic                 timeout_q, timeout_d;
  logic                 have_prev_q, have_prev_d;

  logic                 sat;
  logic [CNT_WIDTH-1:0] cnt_inc;

  assign sat     = (cnt_q == CNT_MAX);
  // Saturating increment: a fall landing exactly on saturation must not wrap.
  assign cnt_inc = sat ? cnt_q : cnt_q + CNT_ONE;

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a qualifying edge always beats saturation.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (rise) state_d = ST_HIGH;
      ST_HIGH: begin
        if (fall)     state_d = ST_LOW;
        else if (sat) state_d = ST_IDLE;
      end
      ST_LOW: begin
        if (rise)     state_d = ST_HIGH;
        else if (sat) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    cnt_d       = cnt_q;
    hi_cap_d    = hi_cap_q;
    period_d    = period_q;
    high_d      = high_q;
    valid_d     = 1'b0;
    locked_d    = locked_q;
    timeout_d   = timeout_q;
    have_prev_d = have_prev_q;
    case (state_q)
      ST_IDLE: if (rise) cnt_d = CNT_ONE;
      ST_HIGH: begin
        if (fall) begin
          hi_cap_d = cnt_q;
          cnt_d    = cnt_inc;
        end else if (sat) begin
          timeout_d   = 1'b1;
          locked_d    = 1'b0;
          have_prev_d = 1'b0;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_LOW: begin
        if (rise) begin
          period_d    = cnt_q;
          high_d      = hi_cap_q;
          valid_d     = 1'b1;
          timeout_d   = 1'b0;
          cnt_d       = CNT_ONE;
          have_prev_d = 1'b1;
          // First period after IDLE has nothing to compare against.
          if (have_prev_q) locked_d = (cnt_q == period_q);
        end else if (sat) begin
          timeout_d   = 1'b1;
          locked_d    = 1'b0;
          have_prev_d = 1'b0;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q       <= '0;
      hi_cap_q    <= '0;
      period_q    <= '0;
      high_q      <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      timeout_q   <= 1'b0;
      have_prev_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      hi_cap_q    <= hi_cap_d;
      period_q    <= period_d;
      high_q      <= high_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
      timeout_q   <= timeout_d;
      have_prev_q <= have_prev_d;
    end
  end

  assign PERIOD    = period_q;
  assign HIGH_TIME = high_q;
  assign VALID     = valid_q;
  assign LOCKED    = locked_q;
  assign TIMEOUT   = timeout_q;

endmodule

// File: tb/tb_blink_meter.sv
// Directed bench for blink_meter (CNT_WIDTH=8, SYNC_STAGES=2).
module tb_blink_meter;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         SIG = 1'b0;
  logic [W-1:0] PERIOD, HIGH_TIME;
  logic         VALID, LOCKED, TIMEOUT;

  always #5 CLK = ~CLK;

  blink_meter #(.CNT_WIDTH(W), .SYNC_STAGES(2)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .SIG       (SIG),
    .PERIOD    (PERIOD),
    .HIGH_TIME (HIGH_TIME),
    .VALID     (VALID),
    .LOCKED    (LOCKED),
    .TIMEOUT   (TIMEOUT)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [31:0] per;
    logic [31:0] hi;
    logic        lk;
    logic        to;
    int          cyc;
  } obs_t;

  obs_t obs_q[$];
  obs_t mon_o;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (VALID === 1'b1) begin
      mon_o.per = 32'(PERIOD);
      mon_o.hi  = 32'(HIGH_TIME);
      mon_o.lk  = LOCKED;
      mon_o.to  = TIMEOUT;
      mon_o.cyc = cyc;
      obs_q.push_back(mon_o);
    end
  end

  // One wave period (h high, l low) per entry. ev/e* describe the VALID
  // produced when this entry's rising edge closes the previous period;
  // *_end are output levels expected once the entry has been driven.
  typedef struct {
    int   h;
    int   l;
    logic ev;
    int   eper;
    int   ehi;
    logic elk;
    int   per_end;
    int   hi_end;
    logic lk_end;
    logic to_end;
  } vec_t;

  vec_t tbl[11];
  vec_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wave(input int h, input int l);
    SIG = 1'b1;
    tick(h);
    SIG = 1'b0;
    tick(l);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_period"},  32'(PERIOD),    0);
    chk({tag, "_high"},    32'(HIGH_TIME), 0);
    chk({tag, "_valid"},   32'(VALID),     0);
    chk({tag, "_locked"},  32'(LOCKED),    0);
    chk({tag, "_timeout"}, 32'(TIMEOUT),   0);
  endtask

  initial begin
    obs_t o;
    int   n;
    int   prev_cyc;

    //        h    l  ev  eper ehi elk  pe  he  lke   toe
    tbl[0]  = '{3,   3, 1'b0, 0, 0, 1'b0, 0, 0, 1'b0, 1'b0};
    tbl[1]  = '{3,   3, 1'b1, 6, 3, 1'b0, 6, 3, 1'b0, 1'b0};
    tbl[2]  = '{3,   3, 1'b1, 6, 3, 1'b1, 6, 3, 1'b1, 1'b0};
    tbl[3]  = '{3,   3, 1'b1, 6, 3, 1'b1, 6, 3, 1'b1, 1'b0};
    tbl[4]  = '{2,   5, 1'b1, 6, 3, 1'b1, 6, 3, 1'b1, 1'b0};
    tbl[5]  = '{2,   5, 1'b1, 7, 2, 1'b0, 7, 2, 1'b0, 1'b0};
    tbl[6]  = '{2,   5, 1'b1, 7, 2, 1'b1, 7, 2, 1'b1, 1'b0};
    tbl[7]  = '{300, 3, 1'b1, 7, 2, 1'b1, 7, 2, 1'b0, 1'b1};
    tbl[8]  = '{3,   3, 1'b0, 0, 0, 1'b0, 7, 2, 1'b0, 1'b1};
    tbl[9]  = '{3,   3, 1'b1, 6, 3, 1'b0, 6, 3, 1'b0, 1'b0};
    tbl[10] = '{3,   3, 1'b1, 6, 3, 1'b1, 6, 3, 1'b1, 1'b0};

    // Reset held while SIG toggles: everything stays at zero.
    RST_N = 1'b0;
    SIG   = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      SIG = ~SIG;
      tick(2);
      chk_all_zero($sformatf("rst%0d", i));
    end
    SIG = 1'b0;
    tick(2);
    RST_N = 1'b1;
    tick(4);
    chk("rst_no_valid", 32'(obs_q.size()), 0);

    // Table-driven periods.
    for (int i = 0; i < 11; i++) begin
      wave(tbl[i].h, tbl[i].l);
      if (tbl[i].ev) exp_q.push_back(tbl[i]);
      chk($sformatf("v%0d_period_end", i), 32'(PERIOD),    32'(tbl[i].per_end));
      chk($sformatf("v%0d_high_end", i),   32'(HIGH_TIME), 32'(tbl[i].hi_end));
      chk($sformatf("v%0d_locked_end", i), 32'(LOCKED),    32'(tbl[i].lk_end));
      chk($sformatf("v%0d_timeout_end", i), 32'(TIMEOUT),  32'(tbl[i].to_end));
    end

    chk("tbl_valid_count", 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int k = 0; k < n; k++) begin
      o = obs_q[k];
      chk($sformatf("valid%0d_period", k),  o.per, 32'(exp_q[k].eper));
      chk($sformatf("valid%0d_high", k),    o.hi,  32'(exp_q[k].ehi));
      chk($sformatf("valid%0d_locked", k),  32'(o.lk), 32'(exp_q[k].elk));
      chk($sformatf("valid%0d_timeout", k), 32'(o.to), 0);
    end

    // Asynchronous reset in the middle of a LOW phase.
    SIG = 1'b1;
    tick(3);
    SIG = 1'b0;
    tick(2);
    chk("pre_arst_period", 32'(PERIOD), 6);
    chk("pre_arst_locked", 32'(LOCKED), 1);
    #2;
    RST_N = 1'b0;
    #1;
    chk_all_zero("arst");
    tick(3);
    RST_N = 1'b1;
    tick(2);
    obs_q.delete();

    // Minimum wave H=L=1, six rises -> five VALIDs two cycles apart.
    for (int i = 0; i < 6; i++) wave(1, 1);
    tick(8);
    chk("min_valid_count", 32'(obs_q.size()), 5);
    prev_cyc = 0;
    for (int k = 0; k < obs_q.size() && k < 5; k++) begin
      o = obs_q[k];
      chk($sformatf("min%0d_period", k), o.per, 2);
      chk($sformatf("min%0d_high", k),   o.hi,  1);
      chk($sformatf("min%0d_locked", k), 32'(o.lk), (k == 0) ? 0 : 1);
      if (k > 0) chk($sformatf("min%0d_spacing", k), 32'(o.cyc - prev_cyc), 2);
      prev_cyc = o.cyc;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
